// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage register with a two-entry skid buffer and synchronous flush.
// All state moves on the falling edge of clk; rst is synchronous and active low.

module pipe_skid_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld_main_in,
  input  logic         ld_main_skid,
  input  logic         ld_skid,
  input  logic [W-1:0] in_d,
  output logic [W-1:0] main_q
);
  logic [W-1:0] skid_q;

  always_ff @(negedge clk) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (clr) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in)        main_q <= in_d;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= in_d;
    end
  end
endmodule

module pipe_skid_stage #(
  parameter int CTRL_W   = 10,
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [1:0]                 occupancy
);
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;

  state_t state, state_nxt;
  logic   in_fire, out_fire;
  logic   ld_main_in, ld_main_skid, ld_skid;
  logic [CTRL_W-1:0]                main_ctrl;
  logic [NUM_DATA-1:0][DATA_W-1:0]  in_lane, main_lane;

  // in_ready depends only on registered state, never on out_ready
  assign in_ready  = rst & (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign in_lane   = in_data;
  assign out_data  = main_lane;

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    occupancy    = 2'd0;
    case (state)
      EMPTY: if (in_fire) begin
        ld_main_in = 1'b1;
        state_nxt  = BUSY;
      end
      BUSY: begin
        occupancy = 2'd1;
        if (in_fire && out_fire) ld_main_in = 1'b1;
        else if (in_fire) begin
          ld_skid   = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) state_nxt = EMPTY;
      end
      FULL: begin
        occupancy = 2'd2;
        if (out_fire) begin
          ld_main_skid = 1'b1;
          state_nxt    = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // flush beats every transfer; a same-edge out_fire is simply consumed
    if (flush) begin
      state_nxt    = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  pipe_skid_lane #(.W(CTRL_W)) u_ctrl (
    .clk(clk), .rst(rst), .clr(flush),
    .ld_main_in(ld_main_in), .ld_main_skid(ld_main_skid), .ld_skid(ld_skid),
    .in_d(in_ctrl), .main_q(main_ctrl)
  );

  // data lanes keep their contents across flush; only ctrl is squashed
  for (genvar g = 0; g < NUM_DATA; g++) begin : g_lane
    pipe_skid_lane #(.W(DATA_W)) u_lane (
      .clk(clk), .rst(rst), .clr(1'b0),
      .ld_main_in(ld_main_in), .ld_main_skid(ld_main_skid), .ld_skid(ld_skid),
      .in_d(in_lane[g]), .main_q(main_lane[g])
    );
  end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table plus randomized run against a queue model,
// driving a default instance and a narrow (CTRL_W=3, NUM_DATA=1, DATA_W=8) instance in parallel.
module tb_pipe_skid_stage;
  localparam int CW = 10, DW = 32, ND = 4;
  localparam int CW2 = 3, DW2 = 8, ND2 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, in_valid, out_ready;
  logic [CW-1:0]    in_ctrl;
  logic [ND*DW-1:0] in_data;
  logic             in_ready, out_valid;
  logic [CW-1:0]    out_ctrl;
  logic [ND*DW-1:0] out_data;
  logic [1:0]       occupancy;
  logic               in_ready2, out_valid2;
  logic [CW2-1:0]     out_ctrl2;
  logic [ND2*DW2-1:0] out_data2;
  logic [1:0]         occupancy2;

  pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .NUM_DATA(ND)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy));

  pipe_skid_stage #(.CTRL_W(CW2), .DATA_W(DW2), .NUM_DATA(ND2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_ctrl(in_ctrl[CW2-1:0]), .in_data(in_data[DW2-1:0]), .out_valid(out_valid2),
    .out_ready(out_ready), .out_ctrl(out_ctrl2), .out_data(out_data2), .occupancy(occupancy2));

  typedef struct {
    logic rst, flush, iv, ordy;
    logic [CW-1:0]    ctrl;
    logic [ND*DW-1:0] data;
    logic             e_valid, e_ready;
    logic [1:0]       e_occ;
    logic [CW-1:0]    e_ctrl;
    logic [ND*DW-1:0] e_data;
  } vec_t;

  typedef struct {
    logic [CW-1:0]    c;
    logic [ND*DW-1:0] d;
  } ent_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [ND*DW-1:0] mk(input logic [31:0] pc);
    return {pc + 32'd3, pc + 32'd2, pc + 32'd1, pc};
  endfunction

  function automatic logic [CW-1:0] cf(input logic [31:0] pc);
    return 10'h200 | pc[9:0];
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic iv, input logic o,
                     input logic [31:0] pc, input logic ev, input logic er,
                     input logic [1:0] eo, input logic [31:0] epc, input logic dz);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.ordy = o;
    v.ctrl = r ? cf(pc) : 10'h3FF;
    v.data = mk(pc);
    v.e_valid = ev; v.e_ready = er; v.e_occ = eo;
    v.e_ctrl = ev ? cf(epc) : '0;
    v.e_data = dz ? '0 : mk(epc);
    vecs.push_back(v);
  endtask

  task automatic check_both(input string tag, input logic ev, input logic er, input logic [1:0] eo,
                            input logic [CW-1:0] ec, input logic [ND*DW-1:0] ed);
    chk({tag, "_valid"}, out_valid, ev);
    chk({tag, "_ready"}, in_ready, er);
    chk({tag, "_occ"},   occupancy, eo);
    chk({tag, "_ctrl"},  out_ctrl, ec);
    chk({tag, "_data"},  out_data, ed);
    chk({tag, "_n_valid"}, out_valid2, ev);
    chk({tag, "_n_ready"}, in_ready2, er);
    chk({tag, "_n_occ"},   occupancy2, eo);
    chk({tag, "_n_ctrl"},  out_ctrl2, ec[CW2-1:0]);
    chk({tag, "_n_data"},  out_data2, ed[DW2-1:0]);
  endtask

  initial begin
    ent_t             q[$];
    ent_t             e;
    logic [ND*DW-1:0] shown;
    logic             m_ir, m_in_fire, m_out_fire;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_ctrl = 10'h3FF; in_data = '0;
    #1;
    chk("rst_comb_ready",   in_ready,  1'b0);
    chk("rst_comb_ready_n", in_ready2, 1'b0);

    // reset, streaming, stall, flush-in-FULL, flush+out_fire, rst+flush mid-operation
    add(0,0,1,1,32'h40, 0,0,2'd0,32'h00,1);
    add(0,0,1,1,32'h40, 0,0,2'd0,32'h00,1);
    add(1,0,0,1,32'h00, 0,1,2'd0,32'h00,1);
    add(1,0,1,1,32'h00, 1,1,2'd1,32'h00,0);
    add(1,0,1,1,32'h04, 1,1,2'd1,32'h04,0);
    add(1,0,1,1,32'h08, 1,1,2'd1,32'h08,0);
    add(1,0,0,1,32'h00, 0,1,2'd0,32'h08,0);
    add(1,0,1,1,32'h10, 1,1,2'd1,32'h10,0);
    add(1,0,1,0,32'h14, 1,0,2'd2,32'h10,0);
    add(1,0,1,0,32'h18, 1,0,2'd2,32'h10,0);
    add(1,0,0,1,32'h00, 1,1,2'd1,32'h14,0);
    add(1,0,0,1,32'h00, 0,1,2'd0,32'h14,0);
    add(1,0,1,0,32'h20, 1,1,2'd1,32'h20,0);
    add(1,0,1,0,32'h24, 1,0,2'd2,32'h20,0);
    add(1,1,1,0,32'h28, 0,1,2'd0,32'h20,0);
    add(1,1,1,0,32'h2C, 0,1,2'd0,32'h20,0);
    add(1,0,0,0,32'h00, 0,1,2'd0,32'h20,0);
    add(1,0,1,1,32'h30, 1,1,2'd1,32'h30,0);
    add(1,1,0,1,32'h00, 0,1,2'd0,32'h30,0);
    add(1,0,0,1,32'h00, 0,1,2'd0,32'h30,0);
    add(1,0,1,0,32'h34, 1,1,2'd1,32'h34,0);
    add(1,0,1,0,32'h38, 1,0,2'd2,32'h34,0);
    add(0,1,1,0,32'h3C, 0,0,2'd0,32'h00,1);
    add(1,0,1,1,32'h40, 1,1,2'd1,32'h40,0);
    add(1,0,0,1,32'h00, 0,1,2'd0,32'h40,0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; flush = vecs[i].flush; in_valid = vecs[i].iv;
      out_ready = vecs[i].ordy; in_ctrl = vecs[i].ctrl; in_data = vecs[i].data;
      @(negedge clk);
      #2;
      check_both($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ready, vecs[i].e_occ,
                 vecs[i].e_ctrl, vecs[i].e_data);
    end

    // randomized run against an arrival-order queue model
    shown = '0;
    for (int c = 0; c < 600; c++) begin
      rst       = (c == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      e.c = CW'($urandom);
      e.d = {$urandom, $urandom, $urandom, $urandom};
      in_ctrl = e.c; in_data = e.d;
      #1;
      m_ir       = rst && (q.size() < 2);
      m_in_fire  = in_valid && m_ir;
      m_out_fire = (q.size() > 0) && out_ready;
      chk("rnd_pre_ready",   in_ready,  m_ir);
      chk("rnd_pre_ready_n", in_ready2, m_ir);
      @(negedge clk);
      if (!rst) begin
        q.delete();
        shown = '0;
      end else if (flush) begin
        q.delete();
      end else begin
        if (m_out_fire) void'(q.pop_front());
        if (m_in_fire)  q.push_back(e);
      end
      if (q.size() > 0) shown = q[0].d;
      #2;
      check_both($sformatf("rnd%0d", c), q.size() > 0, rst && (q.size() < 2), 2'(q.size()),
                 (q.size() > 0) ? q[0].c : '0, shown);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register with valid/ready flow control, a two-entry skid buffer, and synchronous flush. It is the successor to the fixed-width inter-stage registers between the IF/ID/EX/MEM/WB stages. Any stage boundary can use it. Back-pressure (stall) from a later stage no longer drops or duplicates an instruction, and a taken jump can squash the stage in one edge.

## Interface
Parameters:
- CTRL_W, default 10: width of the control bundle (jump, mem, ALU-op, ALU-src and reg-write bits, packed).
- DATA_W, default 32: width of one data lane.
- NUM_DATA, default 4: number of data lanes (pc, operands, immediate, and so on). The bus width is NUM_DATA*DATA_W.

Ports:
- clk, input, 1: stage clock. All state updates on the falling edge, matching the rest of the pipeline.
- rst, input, 1: reset, synchronous and active-low. Sampled on the falling edge of clk.
- flush, input, 1: squash every held entry and the incoming transfer.
- in_valid, input, 1: the upstream stage presents an entry.
- in_ready, output, 1: this stage accepts an entry this cycle.
- in_ctrl, input, CTRL_W: upstream control bundle.
- in_data, input, NUM_DATA*DATA_W: upstream data lanes.
- out_valid, output, 1: the downstream stage sees a valid entry.
- out_ready, input, 1: the downstream stage accepts. Low means stall.
- out_ctrl, output, CTRL_W: control bundle to downstream.
- out_data, output, NUM_DATA*DATA_W: data lanes to downstream.
- occupancy, output, 2: number of held entries (0, 1 or 2).

## Operation
- Transfer events, sampled at the falling edge:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage:
  - main register (ctrl and data), which drives the out_* ports.
  - skid register (ctrl and data).
  - state register with values EMPTY, BUSY and FULL.
- State transitions, all evaluated with flush low and rst high:
  - EMPTY:
    - in_fire: load main, go to BUSY.
    - otherwise: stay in EMPTY.
  - BUSY:
    - in_fire and no out_fire: load skid, go to FULL.
    - in_fire and out_fire: reload main, stay in BUSY.
    - out_fire only: go to EMPTY.
    - neither: hold.
  - FULL:
    - out_fire: copy skid into main, go to BUSY.
    - otherwise: hold.
    - in_fire is impossible in FULL because in_ready is 0.
- Derived outputs:
  - in_ready = rst & (state != FULL). This is a function of registered state only; there is no combinational path from out_ready to in_ready.
  - out_valid = (state != EMPTY).
  - occupancy: 0 in EMPTY, 1 in BUSY, 2 in FULL.
- Bubble rule:
  - Whenever out_valid = 0, out_ctrl is all zeros, so a NOP is seen even by logic that ignores valid.
  - out_data keeps its last loaded value.
- Flush:
  - Flush high at an edge forces EMPTY, clears main ctrl and skid ctrl to 0, and discards any same-edge in_fire.
  - Flush has priority over every transfer.
  - An out_fire on the same edge counts as consumed; downstream owns that entry.
- Ordering:
  - Entries leave in arrival order.
  - No entry is duplicated or lost except by flush or reset.

## Timing
- Reset, when rst is low at a falling edge:
  - state = EMPTY.
  - main and skid ctrl/data all 0.
  - out_valid = 0, out_ctrl = 0, out_data = 0, occupancy = 0.
  - in_ready = 0 combinationally while rst is low.
- Reset mid-operation: all held entries are dropped. The first accept is possible at the first falling edge after rst rises.
- Latency: an in_fire at edge N while EMPTY, or while BUSY with out_fire, gives out_valid and the new out_* values immediately after edge N. This is one stage of latency.
- Throughput: 1 entry per cycle while out_ready stays high.
- Stall absorption:
  - in_ready drops one edge after out_ready drops, with exactly one extra entry absorbed in skid.
  - When out_ready returns, in_ready reasserts after the next edge.
- Simultaneous flush and rst: rst wins, giving the same end state.

## Test plan
- Reset: rst low for 2 edges with in_valid = 1 and in_ctrl = 0x3FF. Required: out_valid = 0, out_ctrl = 0, out_data = 0, occupancy = 0, in_ready = 0. After rst goes high, in_ready = 1.
- Streaming: out_ready held at 1, pc lane of 0x00, 0x04, 0x08 and so on on consecutive edges. Required: each value appears on out_data one edge later, in order; occupancy never exceeds 1.
- Stall: drop out_ready after entry A (0x10) has loaded, while B (0x14) is presented. Required: B goes to skid, occupancy = 2, in_ready = 0. Raise out_ready. Required: A then B emerge on consecutive edges with no duplicates.
- Flush while FULL, with in_valid = 1 carrying C. Required: next edge gives occupancy = 0, out_valid = 0 and out_ctrl = 0. C is never output.
- Flush and out_fire on the same edge in BUSY. Required: the entry counts as consumed once, the next state is EMPTY, and in_ready = 1.
- Parameter sweep with CTRL_W = 3, NUM_DATA = 1 and DATA_W = 8, rerunning the stall scenario. Required: identical ordering and occupancy behaviour.
